// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B4 pipelined RAM slave, in-order queued acks.
// Define WB_RAM_SLAVE_ERR_EN to add wb_err_o for out-of-range addresses.
module wb_ram_slave #(
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o
`ifdef WB_RAM_SLAVE_ERR_EN
  ,
  output logic        wb_err_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [WW-1:0] WT0 =
    (LATENCY > 1) ? WW'(LATENCY - 2) : '0;

  typedef struct packed {
    logic          we;
    logic          err;
    logic [AW-1:0] idx;
    logic [31:0]   dat;
    logic [3:0]    sel;
  } req_t;

  logic [31:0]   mem [DEPTH];
  req_t          q   [FIFO_DEPTH];
  logic [WW-1:0] wt  [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          err_q;
  req_t          in_req;
  req_t          iss;
  logic          acc;
  logic          byp;
  logic          head_rdy;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   rword;
  logic [31:0]   lane_mask;
  logic          unused_bits;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    in_req     = '0;
    in_req.we  = wb_we_i;
    in_req.idx = wb_adr_i[AW+1:2];
    in_req.dat = wb_dat_i;
    in_req.sel = wb_sel_i;
`ifdef WB_RAM_SLAVE_ERR_EN
    in_req.err = |wb_adr_i[31:AW+2];
`endif
  end

  assign unused_bits =
    ^{wb_adr_i[31:AW+2], wb_adr_i[1:0], err_q};

  assign wb_stall_o = (count == CW'(FIFO_DEPTH));
  assign acc = wb_cyc_i & wb_stb_i & ~wb_stall_o;

  // With LATENCY=1 a request is answered on its own
  // acceptance edge, so it bypasses an empty queue.
  assign byp      = (LATENCY == 1) && (count == '0);
  assign head_rdy = (count != '0) && (wt[rd_ptr] == '0);
  assign issue    = head_rdy | (byp & acc);
  assign iss      = head_rdy ? q[rd_ptr] : in_req;
  assign push     = acc & ~byp;
  assign pop      = head_rdy;

  assign rword     = mem[iss.idx];
  assign lane_mask = {{8{iss.sel[3]}}, {8{iss.sel[2]}},
                      {8{iss.sel[1]}}, {8{iss.sel[0]}}};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wb_ack_o <= 1'b0;
      err_q    <= 1'b0;
      wb_dat_o <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) wt[i] <= '0;
    end else if (!wb_cyc_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wb_ack_o <= 1'b0;
      err_q    <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (wt[i] != '0) wt[i] <= wt[i] - WW'(1);
      end
      if (push) begin
        wt[wr_ptr] <= WT0;
        wr_ptr     <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push != pop)
        count <= push ? count + CW'(1) : count - CW'(1);
      wb_ack_o <= issue & ~iss.err;
      err_q    <= issue & iss.err;
      wb_dat_o <= (issue & ~iss.we & ~iss.err) ?
                  (rword & lane_mask) : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) q[wr_ptr] <= in_req;
  end

  // Writes commit only when acked, so an abort drops them.
  always_ff @(posedge clk_i) begin
    if (rst_i && wb_cyc_i && issue && iss.we && !iss.err) begin
      for (int b = 0; b < 4; b++) begin
        if (iss.sel[b])
          mem[iss.idx][8*b +: 8] <= iss.dat[8*b +: 8];
      end
    end
  end

`ifdef WB_RAM_SLAVE_ERR_EN
  assign wb_err_o = err_q;
`endif

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: scoreboard bench for two slave configurations.
// dut0: LATENCY=1 FIFO_DEPTH=4, dut1: LATENCY=4 FIFO_DEPTH=2.
module tb_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        we   [2];
  logic [3:0]  sel  [2];
  logic        stb  [2];
  logic        cyc  [2];
  logic        ack  [2];
  logic        stall[2];
  logic        err  [2];

  typedef struct {
    logic [31:0] dat;
    bit          chk;
    bit          err;
    int          edge_n;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ecnt = 0;
  int   last_ack[2];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  wb_ram_slave #(.DEPTH(1024), .LATENCY(1), .FIFO_DEPTH(4)) u_a (
    .clk_i(clk), .rst_i(rst_n),
    .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
    .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_stb_i(stb[0]),
    .wb_cyc_i(cyc[0]), .wb_ack_o(ack[0]), .wb_stall_o(stall[0])
`ifdef WB_RAM_SLAVE_ERR_EN
    , .wb_err_o(err[0])
`endif
  );

  wb_ram_slave #(.DEPTH(1024), .LATENCY(4), .FIFO_DEPTH(2)) u_b (
    .clk_i(clk), .rst_i(rst_n),
    .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
    .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_stb_i(stb[1]),
    .wb_cyc_i(cyc[1]), .wb_ack_o(ack[1]), .wb_stall_o(stall[1])
`ifdef WB_RAM_SLAVE_ERR_EN
    , .wb_err_o(err[1])
`endif
  );

`ifndef WB_RAM_SLAVE_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  task automatic cmp(input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h", nm, d, act, exp);
    end
  endtask

  task automatic mon(input int d);
    exp_t x;
    bit   have;
    if (ack[d] === 1'b1 || err[d] === 1'b1) begin
      have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (!have) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack dut%0d: got ack=%b err=%b want none",
                 d, ack[d], err[d]);
      end else begin
        if (d == 0) x = q0.pop_front();
        else x = q1.pop_front();
        cmp("ack_edge", d, 32'(ecnt), 32'(x.edge_n));
        cmp("ack_kind", d, {30'd0, ack[d], err[d]},
            x.err ? 32'd1 : 32'd2);
        if (x.chk) cmp("rd_data", d, rdat[d], x.dat);
      end
    end else begin
      cmp("idle_dat", d, rdat[d], 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic req(input int d, input bit w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] s,
                     input logic [31:0] ed, input bit chk, input bit e);
    exp_t x;
    int   n;
    int   lat;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
    adr[d] = a; wdat[d] = wd; sel[d] = s;
    n = 0;
    while (stall[d] === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stall_timeout dut%0d: got stall=1 want 0", d);
    end else begin
      lat = (d == 0) ? 1 : 4;
      x.edge_n = (ecnt + lat > last_ack[d]) ? ecnt + lat
                                            : last_ack[d] + 1;
      last_ack[d] = x.edge_n;
      x.dat = ed;
      x.chk = chk;
      x.err = e;
      if (d == 0) q0.push_back(x);
      else q1.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int d);
    stb[d] = 1'b0;
    we[d]  = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    idle(d);
    n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (((d == 0) ? q0.size() : q1.size()) != 0) begin
      n_bad++;
      $display("FAIL drain_timeout dut%0d: got %0d pending want 0", d,
               (d == 0) ? q0.size() : q1.size());
      if (d == 0) q0.delete();
      else q1.delete();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      adr[d] = '0; wdat[d] = '0; we[d] = 1'b0; sel[d] = '0;
      stb[d] = 1'b0; cyc[d] = 1'b0; last_ack[d] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cmp("rst_ack", d, 32'(ack[d]), 32'd0);
      cmp("rst_dat", d, rdat[d], 32'd0);
      cmp("rst_stall", d, 32'(stall[d]), 32'd0);
    end
    rst_n = 1'b1;
    cyc[0] = 1'b1;
    cyc[1] = 1'b1;
    @(negedge clk);

    // basic write then read
    req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    idle(0);
    @(negedge clk);
    req(0, 0, 32'h10, 0, 4'hF, 32'hDEADBEEF, 1, 0);
    // byte lanes, back to back
    req(0, 1, 32'h20, 32'h11223344, 4'hF, 0, 0, 0);
    req(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 0, 0);
    req(0, 0, 32'h20, 0, 4'hF, 32'h11BB33DD, 1, 0);
    req(0, 0, 32'h22, 0, 4'h3, 32'h000033DD, 1, 0);
    // read after write on consecutive cycles
    req(0, 1, 32'h40, 32'h5, 4'hF, 0, 0, 0);
    req(0, 0, 32'h40, 0, 4'hF, 32'h5, 1, 0);
`ifdef WB_RAM_SLAVE_ERR_EN
    req(0, 1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    req(0, 1, 32'h1000, 32'h11111111, 4'hF, 0, 1, 1);
    req(0, 0, 32'h1000, 0, 4'hF, 32'h0, 1, 1);
    req(0, 0, 32'h0, 0, 4'hF, 32'hCAFEF00D, 1, 0);
`else
    req(0, 0, 32'h1010, 0, 4'hF, 32'hDEADBEEF, 1, 0);
`endif
    drain(0);
    // strobe without cycle is ignored
    cyc[0] = 1'b0; stb[0] = 1'b1; adr[0] = 32'h10;
    @(negedge clk);
    @(negedge clk);
    stb[0] = 1'b0; cyc[0] = 1'b1;
    @(negedge clk);
    cmp("stall_idle", 0, 32'(stall[0]), 32'd0);

    // backpressure: prefill, then five reads with stb held
    for (int i = 0; i < 5; i++)
      req(1, 1, 32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF, 0, 0, 0);
    drain(1);
    req(1, 0, 32'h100, 0, 4'hF, 32'hA0000000, 1, 0);
    req(1, 0, 32'h104, 0, 4'hF, 32'hA0000001, 1, 0);
    cmp("stall_full", 1, 32'(stall[1]), 32'd1);
    req(1, 0, 32'h108, 0, 4'hF, 32'hA0000002, 1, 0);
    req(1, 0, 32'h10C, 0, 4'hF, 32'hA0000003, 1, 0);
    req(1, 0, 32'h110, 0, 4'hF, 32'hA0000004, 1, 0);
    drain(1);
    cmp("stall_drained", 1, 32'(stall[1]), 32'd0);

    // abort drops an uncommitted write
    req(1, 1, 32'h80, 32'h12345678, 4'hF, 0, 0, 0);
    drain(1);
    req(1, 1, 32'h80, 32'h77, 4'hF, 0, 0, 0);
    cyc[1] = 1'b0;
    idle(1);
    q1.delete();
    last_ack[1] = 0;
    repeat (3) @(negedge clk);
    cyc[1] = 1'b1;
    repeat (4) @(negedge clk);
    cmp("stall_abort", 1, 32'(stall[1]), 32'd0);
    req(1, 0, 32'h80, 0, 4'hF, 32'h12345678, 1, 0);
    drain(1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
